dsp_cascade: RTL and testbench

- 5-tap pixel convolution kernel: multiplies five 8-bit unsigned pixels by signed constant coefficients.
- Products are summed through a systolic chain of multiply-accumulate stages, one DSP slice per tap, linked by a PCOUT→PCIN style cascade.
- The sum is scaled by a right shift and clamped to 8 bits.
- Sits in the HDMI convolution-filter datapath; the line-buffer/window logic feeds pa..pe, and p_out goes to the output pixel stream.

---
 rtl/dsp_cascade_pkg.sv | 39 +++
 rtl/dsp_mac_stage.sv | 31 +++
 rtl/dsp_cascade.sv | 77 +++++++
 tb/tb_dsp_cascade.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dsp_cascade_pkg.sv
// Shared widths, default coefficients and the output clamp for the 5-tap
// cascaded-MAC pixel convolution kernel.
package dsp_cascade_pkg;

    localparam int unsigned PIX_W    = 8;
    localparam int unsigned COEF_W   = 8;
    localparam int unsigned PROD_W   = 17;
    localparam int unsigned ACC_W    = 20;
    localparam int unsigned LATENCY  = 7;
    localparam int unsigned NUM_TAPS = 5;

    localparam int          DEF_COEF_A = 1;
    localparam int          DEF_COEF_B = 4;
    localparam int          DEF_COEF_C = 6;
    localparam int          DEF_COEF_D = 4;
    localparam int          DEF_COEF_E = 1;
    localparam int unsigned DEF_SHIFT  = 4;

    // One sampled 5-pixel window
    typedef struct packed {
        logic [PIX_W-1:0] pa;
        logic [PIX_W-1:0] pb;
        logic [PIX_W-1:0] pc;
        logic [PIX_W-1:0] pd;
        logic [PIX_W-1:0] pe;
    } pix_win_t;

    // Saturate a signed accumulator value into an unsigned pixel
    function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [ACC_W-1:0] r);
        if (r[ACC_W-1]) begin
            return '0;
        end else if (r > ACC_W'(255)) begin
            return '1;
        end else begin
            return r[PIX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/dsp_mac_stage.sv
// One DSP-slice equivalent: registered pcout = pcin + coef * pixel.
module dsp_mac_stage
    import dsp_cascade_pkg::*;
#(
    parameter int COEF = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PIX_W-1:0]        pixel,
    input  logic signed [ACC_W-1:0] pcin,
    output logic signed [ACC_W-1:0] pcout
);

    localparam logic signed [COEF_W-1:0] COEF_S = COEF_W'(COEF);

    logic signed [PIX_W:0]    pix_s;
    logic signed [PROD_W-1:0] prod_c;

    // Pixel is unsigned, so zero-extend before the signed multiply
    assign pix_s  = $signed({1'b0, pixel});
    assign prod_c = PROD_W'(pix_s) * PROD_W'(COEF_S);

    always_ff @(posedge clk) begin
        if (!rst) begin
            pcout <= '0;
        end else begin
            pcout <= pcin + ACC_W'(prod_c);
        end
    end

endmodule

// File: rtl/dsp_cascade.sv
// 5-tap pixel convolution: input register, five cascaded MAC stages with
// delay-balanced taps, then shift-and-clamp output register (7 cycles).
module dsp_cascade
    import dsp_cascade_pkg::*;
#(
    parameter int          COEF_A = DEF_COEF_A,
    parameter int          COEF_B = DEF_COEF_B,
    parameter int          COEF_C = DEF_COEF_C,
    parameter int          COEF_D = DEF_COEF_D,
    parameter int          COEF_E = DEF_COEF_E,
    parameter int unsigned SHIFT  = DEF_SHIFT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pa,
    input  logic [PIX_W-1:0] pb,
    input  logic [PIX_W-1:0] pc,
    input  logic [PIX_W-1:0] pd,
    input  logic [PIX_W-1:0] pe,
    output logic [PIX_W-1:0] p_out
);

    pix_win_t                   win_q;
    logic [PIX_W-1:0]           b_dly;
    logic [1:0][PIX_W-1:0]      c_dly;
    logic [2:0][PIX_W-1:0]      d_dly;
    logic [3:0][PIX_W-1:0]      e_dly;
    logic signed [ACC_W-1:0]    casc [NUM_TAPS+1];
    logic signed [ACC_W-1:0]    scaled_c;

    // Input register plus delay lines so stage k sees the window from k cycles back
    always_ff @(posedge clk) begin
        if (!rst) begin
            win_q <= '0;
            b_dly <= '0;
            c_dly <= '0;
            d_dly <= '0;
            e_dly <= '0;
        end else begin
            win_q <= '{pa: pa, pb: pb, pc: pc, pd: pd, pe: pe};
            b_dly <= win_q.pb;
            c_dly <= {c_dly[0], win_q.pc};
            d_dly <= {d_dly[1:0], win_q.pd};
            e_dly <= {e_dly[2:0], win_q.pe};
        end
    end

    assign casc[0] = '0;

    dsp_mac_stage #(.COEF(COEF_A)) u_mac_a (
        .clk(clk), .rst(rst), .pixel(win_q.pa), .pcin(casc[0]), .pcout(casc[1])
    );
    dsp_mac_stage #(.COEF(COEF_B)) u_mac_b (
        .clk(clk), .rst(rst), .pixel(b_dly),    .pcin(casc[1]), .pcout(casc[2])
    );
    dsp_mac_stage #(.COEF(COEF_C)) u_mac_c (
        .clk(clk), .rst(rst), .pixel(c_dly[1]), .pcin(casc[2]), .pcout(casc[3])
    );
    dsp_mac_stage #(.COEF(COEF_D)) u_mac_d (
        .clk(clk), .rst(rst), .pixel(d_dly[2]), .pcin(casc[3]), .pcout(casc[4])
    );
    dsp_mac_stage #(.COEF(COEF_E)) u_mac_e (
        .clk(clk), .rst(rst), .pixel(e_dly[3]), .pcin(casc[4]), .pcout(casc[5])
    );

    // Floor scaling: arithmetic shift, no rounding
    assign scaled_c = casc[NUM_TAPS] >>> SHIFT;

    always_ff @(posedge clk) begin
        if (!rst) begin
            p_out <= '0;
        end else begin
            p_out <= clamp_pix(scaled_c);
        end
    end

endmodule

// File: tb/tb_dsp_cascade.sv
// Randomized and directed bench for dsp_cascade against a history-based reference model.
module tb_dsp_cascade;

    localparam int MAXE = 4096;
    localparam int NI   = 3;

    logic       clk;
    logic       rst;
    logic [7:0] pa, pb, pc, pd, pe;
    logic [7:0] p_def, p_neg, p_pos;

    int  vectors    = 0;
    int  miscompares = 0;
    int  n_edges    = 0;
    bit  h_rst [MAXE];
    int  h_px  [MAXE][5];

    bit  lit_en = 0;
    int  lit_exp [NI];

    // Coefficient sets for the three instances: {a,b,c,d,e,shift}
    int  cfg [NI][6] = '{'{1, 4, 6, 4, 1, 4}, '{-1, 0, 0, 0, 0, 0}, '{0, 0, 2, 0, 0, 0}};

    dsp_cascade u_def (
        .clk(clk), .rst(rst), .pa(pa), .pb(pb), .pc(pc), .pd(pd), .pe(pe), .p_out(p_def)
    );
    dsp_cascade #(.COEF_A(-1), .COEF_B(0), .COEF_C(0), .COEF_D(0), .COEF_E(0), .SHIFT(0)) u_neg (
        .clk(clk), .rst(rst), .pa(pa), .pb(pb), .pc(pc), .pd(pd), .pe(pe), .p_out(p_neg)
    );
    dsp_cascade #(.COEF_A(0), .COEF_B(0), .COEF_C(2), .COEF_D(0), .COEF_E(0), .SHIFT(0)) u_pos (
        .clk(clk), .rst(rst), .pa(pa), .pb(pb), .pc(pc), .pd(pd), .pe(pe), .p_out(p_pos)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Filter formula on one sampled window
    function automatic int filt(input int inst, input int idx);
        int s, r;
        s = 0;
        for (int k = 0; k < 5; k++) s += cfg[inst][k] * h_px[idx][k];
        r = s >>> cfg[inst][5];
        if (r < 0) return 0;
        if (r > 255) return 255;
        return r;
    endfunction

    // Output after the latest edge: window sampled 6 edges earlier, unless any reset intervened
    function automatic int expected(input int inst);
        if (n_edges < 7) return 0;
        for (int i = n_edges - 7; i < n_edges; i++)
            if (!h_rst[i]) return 0;
        return filt(inst, n_edges - 7);
    endfunction

    always @(posedge clk) begin
        if (n_edges < MAXE) begin
            h_rst[n_edges] = rst;
            h_px[n_edges][0] = int'(pa);
            h_px[n_edges][1] = int'(pb);
            h_px[n_edges][2] = int'(pc);
            h_px[n_edges][3] = int'(pd);
            h_px[n_edges][4] = int'(pe);
            n_edges = n_edges + 1;
        end
    end

    always @(negedge clk) begin
        if (n_edges > 0) begin
            int act [NI];
            int e;
            act[0] = int'(p_def);
            act[1] = int'(p_neg);
            act[2] = int'(p_pos);
            for (int i = 0; i < NI; i++) begin
                e = expected(i);
                vectors++;
                if (act[i] !== e) begin
                    miscompares++;
                    $display("FAIL model inst%0d edge%0d: p_out=%0d expected=%0d", i, n_edges, act[i], e);
                end
                if (lit_en) begin
                    vectors++;
                    if (act[i] !== lit_exp[i]) begin
                        miscompares++;
                        $display("FAIL literal inst%0d edge%0d: p_out=%0d expected=%0d",
                                 i, n_edges, act[i], lit_exp[i]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        lit_en = 0;
    endtask

    task automatic set_px(input int a, input int b, input int c, input int d, input int e);
        pa = 8'(a); pb = 8'(b); pc = 8'(c); pd = 8'(d); pe = 8'(e);
    endtask

    task automatic expect_lit(input int d, input int n, input int p);
        lit_exp[0] = d; lit_exp[1] = n; lit_exp[2] = p;
        lit_en = 1;
    endtask

    task automatic rand_px();
        if ($urandom_range(0, 7) == 0)
            set_px($urandom_range(0, 1) * 255, $urandom_range(0, 1) * 255, $urandom_range(0, 1) * 255,
                   $urandom_range(0, 1) * 255, $urandom_range(0, 1) * 255);
        else
            set_px($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 255), $urandom_range(0, 255));
    endtask

    initial begin
        rst = 0;
        set_px(0, 0, 0, 0, 0);
        repeat (3) tick();

        // Constant window after reset: 13 from the 7th edge onward
        rst = 1;
        set_px(1, 34, 4, 8, 16);
        repeat (6) begin
            tick();
            expect_lit(0, 0, 0);
        end
        tick();
        expect_lit(13, 0, 8);
        repeat (3) tick();
        expect_lit(13, 0, 8);

        set_px(255, 255, 255, 255, 255);
        repeat (7) tick();
        expect_lit(255, 0, 255);

        set_px(0, 0, 0, 0, 0);
        repeat (7) tick();
        expect_lit(0, 0, 0);

        // Single-cycle impulse on pc
        set_px(0, 0, 16, 0, 0);
        tick();
        set_px(0, 0, 0, 0, 0);
        repeat (5) begin
            tick();
            expect_lit(0, 0, 0);
        end
        tick();
        expect_lit(6, 0, 32);
        tick();
        expect_lit(0, 0, 0);

        set_px(5, 0, 0, 0, 0);
        repeat (7) tick();
        expect_lit(0, 0, 0);

        set_px(0, 0, 200, 0, 0);
        repeat (7) tick();
        expect_lit(75, 0, 255);

        // Streaming with a one-edge reset in the middle
        repeat (20) begin
            rand_px();
            tick();
        end
        rst = 0;
        rand_px();
        tick();
        expect_lit(0, 0, 0);
        rst = 1;
        repeat (6) begin
            rand_px();
            tick();
            expect_lit(0, 0, 0);
        end
        repeat (20) begin
            rand_px();
            tick();
        end

        repeat (500) begin
            rst = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
            rand_px();
            tick();
        end
        rst = 1;
        repeat (10) tick();

        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
